// File: rtl/key_fifo_ctrl_if.sv
// FIFO-side signal bundle between key_fifo_ctrl (master) and the FIFO IP (slave).
interface key_fifo_ctrl_if #(
  parameter int DW = 8
);
  logic          fifo_wrreq;
  logic [DW-1:0] fifo_data;
  logic          fifo_rdreq;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_q;

  modport master (
    output fifo_wrreq, fifo_data, fifo_rdreq,
    input  fifo_full, fifo_empty, fifo_q
  );

  modport slave (
    input  fifo_wrreq, fifo_data, fifo_rdreq,
    output fifo_full, fifo_empty, fifo_q
  );
endinterface

// File: rtl/key_fifo_ctrl.sv
// Turns debounced write/read key presses into single FIFO strobes, with one-deep
// press queues, full/empty rejection and a fixed read-latency wait before capture.
module key_fifo_ctrl #(
  parameter int DW        = 8,
  parameter int DATA_INIT = 0,
  parameter int RD_LAT    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_wr_n,
  input  logic            key_rd_n,
  key_fifo_ctrl_if.master fifo,
  output logic [DW-1:0]   disp_data,
  output logic            disp_valid,
  output logic            err_full,
  output logic            err_empty,
  output logic            busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  localparam logic [DW-1:0] DATA_RST = DW'(DATA_INIT);
  localparam logic [2:0]    LAT_LOAD = 3'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic          key_wr_prev_q, key_wr_prev_d, key_rd_prev_q, key_rd_prev_d;
  logic          wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic [2:0]    lat_q, lat_d;
  logic          fifo_wrreq_q, fifo_wrreq_d, fifo_rdreq_q, fifo_rdreq_d;
  logic [DW-1:0] fifo_data_q, fifo_data_d, disp_data_q, disp_data_d;
  logic          disp_valid_q, disp_valid_d, err_full_q, err_full_d;
  logic          err_empty_q, err_empty_d, busy_q, busy_d;
  logic          wr_fall, rd_fall, wr_clr, rd_clr;

  // Next-state, registered-output and pending-flag logic.
  always_comb begin
    state_d       = state_q;
    key_wr_prev_d = key_wr_n;
    key_rd_prev_d = key_rd_n;
    lat_d         = lat_q;
    fifo_wrreq_d  = 1'b0;
    fifo_rdreq_d  = 1'b0;
    fifo_data_d   = fifo_data_q;
    disp_data_d   = disp_data_q;
    disp_valid_d  = 1'b0;
    err_full_d    = 1'b0;
    err_empty_d   = 1'b0;
    wr_clr        = 1'b0;
    rd_clr        = 1'b0;
    wr_fall       = key_wr_prev_q & ~key_wr_n;
    rd_fall       = key_rd_prev_q & ~key_rd_n;

    case (state_q)
      ST_IDLE: begin
        if (wr_pend_q) begin
          if (fifo.fifo_full) begin
            err_full_d = 1'b1;
            wr_clr     = 1'b1;
          end else begin
            state_d      = ST_WRITE;
            fifo_wrreq_d = 1'b1;
          end
        end else if (rd_pend_q) begin
          if (fifo.fifo_empty) begin
            err_empty_d = 1'b1;
            rd_clr      = 1'b1;
          end else begin
            state_d      = ST_READ;
            fifo_rdreq_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wr_clr      = 1'b1;
        fifo_data_d = fifo_data_q + DW'(1);
        state_d     = ST_IDLE;
      end
      ST_READ: begin
        rd_clr  = 1'b1;
        lat_d   = LAT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // fifo_q is valid on the edge that leaves WAIT, so capture happens here.
        if (lat_q == 3'd0) begin
          state_d      = ST_CAPTURE;
          disp_data_d  = fifo.fifo_q;
          disp_valid_d = 1'b1;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A press landing while its flag is still set is dropped, including on the clearing edge.
    wr_pend_d = wr_pend_q ? ~wr_clr : wr_fall;
    rd_pend_d = rd_pend_q ? ~rd_clr : rd_fall;
    busy_d    = (state_d != ST_IDLE);
  end

  // State, key history, pending flags and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      key_wr_prev_q <= 1'b1;
      key_rd_prev_q <= 1'b1;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      lat_q         <= 3'd0;
      fifo_wrreq_q  <= 1'b0;
      fifo_rdreq_q  <= 1'b0;
      fifo_data_q   <= DATA_RST;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      err_full_q    <= 1'b0;
      err_empty_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_wr_prev_q <= key_wr_prev_d;
      key_rd_prev_q <= key_rd_prev_d;
      wr_pend_q     <= wr_pend_d;
      rd_pend_q     <= rd_pend_d;
      lat_q         <= lat_d;
      fifo_wrreq_q  <= fifo_wrreq_d;
      fifo_rdreq_q  <= fifo_rdreq_d;
      fifo_data_q   <= fifo_data_d;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      err_full_q    <= err_full_d;
      err_empty_q   <= err_empty_d;
      busy_q        <= busy_d;
    end
  end

  assign fifo.fifo_wrreq = fifo_wrreq_q;
  assign fifo.fifo_rdreq = fifo_rdreq_q;
  assign fifo.fifo_data  = fifo_data_q;
  assign disp_data       = disp_data_q;
  assign disp_valid      = disp_valid_q;
  assign err_full        = err_full_q;
  assign err_empty       = err_empty_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_key_fifo_ctrl.sv
// Bench for key_fifo_ctrl: two configurations share key stimulus; a schedule-based
// reference with a FIFO model checks every cycle, plus a table of press scenarios.
module tb_key_fifo_ctrl;

  localparam int DEPTH = 4;
  localparam int K_W = 0, K_R = 1, K_FF = 2, K_EE = 3, K_B = 4;

  typedef struct packed {
    logic       wrreq, rdreq, dv, ef, ee, busy;
    logic [7:0] data, disp;
  } out_t;

  typedef struct packed {
    logic [3:0] wr_off, rd_off, dv_off, ef_off, ee_off;
    logic [2:0] n_wr, n_rd, n_dv, n_ef, n_ee;
    logic [7:0] wdata, disp;
  } sig_t;

  typedef struct {
    bit         rst, wr, rd;
    int         kind;
    logic [7:0] d0, d1, x0, x1;
  } vec_t;

  logic clk, rst_n, key_wr_n, key_rd_n;
  logic [7:0] disp0, disp1;
  logic dv0, dv1, ef0, ef1, ee0, ee1, busy0, busy1;
  logic [1:0] f_full, f_empty;
  logic [7:0] f_q [2];

  key_fifo_ctrl_if #(.DW(8)) bus0 ();
  key_fifo_ctrl_if #(.DW(8)) bus1 ();

  assign bus0.fifo_full  = f_full[0];
  assign bus0.fifo_empty = f_empty[0];
  assign bus0.fifo_q     = f_q[0];
  assign bus1.fifo_full  = f_full[1];
  assign bus1.fifo_empty = f_empty[1];
  assign bus1.fifo_q     = f_q[1];

  key_fifo_ctrl #(.DW(8), .DATA_INIT(0), .RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .key_wr_n(key_wr_n), .key_rd_n(key_rd_n), .fifo(bus0),
    .disp_data(disp0), .disp_valid(dv0), .err_full(ef0), .err_empty(ee0), .busy(busy0));

  key_fifo_ctrl #(.DW(8), .DATA_INIT(8'hFE), .RD_LAT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_wr_n(key_wr_n), .key_rd_n(key_rd_n), .fifo(bus1),
    .disp_data(disp1), .disp_valid(dv1), .err_full(ef1), .err_empty(ee1), .busy(busy1));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;
  int edge_n = 0;
  int rd_lat [2] = '{1, 3};
  logic [7:0] dinit [2] = '{8'h00, 8'hFE};

  // Reference state: which edge each action lands on, plus the FIFO contents.
  int         m_busy_until [2], m_wr_edge [2], m_rd_edge [2], m_cap_edge [2], m_words [2];
  bit         m_prev_wr [2], m_prev_rd [2], m_wr_pend [2], m_rd_pend [2];
  logic [7:0] m_cnt [2], m_disp [2], m_qword [2];
  logic [7:0] m_mem [2][8];
  out_t       m_exp [2];
  logic       nx_full [2], nx_empty [2];
  logic [7:0] nx_q [2];
  vec_t       vecs [$];

  function automatic out_t get_out(input int c);
    if (c == 0)
      return {bus0.fifo_wrreq, bus0.fifo_rdreq, dv0, ef0, ee0, busy0, bus0.fifo_data, disp0};
    else
      return {bus1.fifo_wrreq, bus1.fifo_rdreq, dv1, ef1, ee1, busy1, bus1.fifo_data, disp1};
  endfunction

  task automatic model_reset(input int c);
    m_busy_until[c] = -1;
    m_wr_edge[c]    = -100;
    m_rd_edge[c]    = -100;
    m_cap_edge[c]   = -100;
    m_words[c]      = 0;
    m_prev_wr[c]    = 1'b1;
    m_prev_rd[c]    = 1'b1;
    m_wr_pend[c]    = 1'b0;
    m_rd_pend[c]    = 1'b0;
    m_cnt[c]        = dinit[c];
    m_disp[c]       = 8'h00;
    m_qword[c]      = 8'h00;
    m_exp[c]        = {6'b000000, dinit[c], 8'h00};
    nx_full[c]      = 1'b0;
    nx_empty[c]     = 1'b1;
    nx_q[c]         = 8'($urandom);
  endtask

  task automatic model_edge(input int c, input bit wr_n, input bit rd_n);
    int n;
    bit fw, fr, cw, cr;
    n  = edge_n;
    fw = m_prev_wr[c] & ~wr_n;
    fr = m_prev_rd[c] & ~rd_n;
    m_prev_wr[c] = wr_n;
    m_prev_rd[c] = rd_n;
    cw = (n == m_wr_edge[c] + 1);
    cr = (n == m_rd_edge[c] + 1);
    m_exp[c].ef = 1'b0;
    m_exp[c].ee = 1'b0;
    if (n > m_busy_until[c]) begin
      if (m_wr_pend[c]) begin
        if (m_words[c] == DEPTH) begin
          m_exp[c].ef = 1'b1;
          cw = 1'b1;
        end else begin
          m_wr_edge[c]    = n;
          m_busy_until[c] = n + 1;
        end
      end else if (m_rd_pend[c]) begin
        if (m_words[c] == 0) begin
          m_exp[c].ee = 1'b1;
          cr = 1'b1;
        end else begin
          m_rd_edge[c]    = n;
          m_cap_edge[c]   = n + 1 + rd_lat[c];
          m_busy_until[c] = n + 2 + rd_lat[c];
        end
      end
    end
    if (n == m_wr_edge[c] + 1) begin
      m_mem[c][m_words[c]] = m_cnt[c];
      m_words[c] = m_words[c] + 1;
      m_cnt[c]   = m_cnt[c] + 8'd1;
    end
    if (n == m_rd_edge[c] + 1) begin
      m_qword[c] = m_mem[c][0];
      for (int i = 0; i < 7; i++) m_mem[c][i] = m_mem[c][i+1];
      m_words[c] = m_words[c] - 1;
    end
    if (n == m_cap_edge[c]) m_disp[c] = m_qword[c];
    m_wr_pend[c]   = m_wr_pend[c] ? !cw : fw;
    m_rd_pend[c]   = m_rd_pend[c] ? !cr : fr;
    m_exp[c].wrreq = (n == m_wr_edge[c]);
    m_exp[c].rdreq = (n == m_rd_edge[c]);
    m_exp[c].dv    = (n == m_cap_edge[c]);
    m_exp[c].busy  = (n < m_busy_until[c]);
    m_exp[c].data  = m_cnt[c];
    m_exp[c].disp  = m_disp[c];
    nx_full[c]     = (m_words[c] == DEPTH);
    nx_empty[c]    = (m_words[c] == 0);
    nx_q[c]        = (n + 1 == m_cap_edge[c]) ? m_qword[c] : 8'($urandom);
  endtask

  task automatic apply_drv();
    for (int c = 0; c < 2; c++) begin
      f_full[c]  = nx_full[c];
      f_empty[c] = nx_empty[c];
      f_q[c]     = nx_q[c];
    end
  endtask

  task automatic check_all();
    out_t o;
    for (int c = 0; c < 2; c++) begin
      o = get_out(c);
      n_checks++;
      if (o !== m_exp[c]) begin
        n_err++;
        $display("FAIL cycle dut%0d edge %0d: got %h expected %h (wr,rd,dv,ef,ee,busy,data,disp)",
                 c, edge_n, o, m_exp[c]);
      end
    end
  endtask

  // One clock: keys change at the negedge, model steps at the posedge, check at next negedge.
  task automatic cyc(input bit wr_n, input bit rd_n);
    key_wr_n = wr_n;
    key_rd_n = rd_n;
    @(posedge clk);
    edge_n++;
    for (int c = 0; c < 2; c++) begin
      if (rst_n) model_edge(c, wr_n, rd_n);
      else model_reset(c);
    end
    @(negedge clk);
    apply_drv();
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    for (int c = 0; c < 2; c++) model_reset(c);
    apply_drv();
    #1 check_all();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  function automatic sig_t exp_sig(input int kind, input int lat, input logic [7:0] d,
                                   input logic [7:0] x);
    sig_t s;
    s = '0;
    case (kind)
      K_W:  begin s.wr_off = 4'd1; s.n_wr = 3'd1; s.wdata = d; end
      K_R:  begin s.rd_off = 4'd1; s.n_rd = 3'd1; s.dv_off = 4'(2 + lat); s.n_dv = 3'd1; s.disp = x; end
      K_FF: begin s.ef_off = 4'd1; s.n_ef = 3'd1; end
      K_EE: begin s.ee_off = 4'd1; s.n_ee = 3'd1; end
      K_B:  begin
        s.wr_off = 4'd1; s.n_wr = 3'd1; s.wdata = d;
        s.rd_off = 4'd3; s.n_rd = 3'd1; s.dv_off = 4'(4 + lat); s.n_dv = 3'd1; s.disp = x;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    sig_t got [2];
    sig_t exp;
    out_t o;
    if (v.rst) do_reset();
    got[0] = '0;
    got[1] = '0;
    for (int k = 0; k < 14; k++) begin
      cyc((v.wr && k < 10) ? 1'b0 : 1'b1, (v.rd && k < 10) ? 1'b0 : 1'b1);
      for (int c = 0; c < 2; c++) begin
        o = get_out(c);
        if (o.wrreq) begin
          if (got[c].n_wr == 3'd0) begin got[c].wr_off = 4'(k); got[c].wdata = o.data; end
          if (got[c].n_wr != 3'd7) got[c].n_wr = got[c].n_wr + 3'd1;
        end
        if (o.rdreq) begin
          if (got[c].n_rd == 3'd0) got[c].rd_off = 4'(k);
          if (got[c].n_rd != 3'd7) got[c].n_rd = got[c].n_rd + 3'd1;
        end
        if (o.dv) begin
          if (got[c].n_dv == 3'd0) begin got[c].dv_off = 4'(k); got[c].disp = o.disp; end
          if (got[c].n_dv != 3'd7) got[c].n_dv = got[c].n_dv + 3'd1;
        end
        if (o.ef) begin
          if (got[c].n_ef == 3'd0) got[c].ef_off = 4'(k);
          if (got[c].n_ef != 3'd7) got[c].n_ef = got[c].n_ef + 3'd1;
        end
        if (o.ee) begin
          if (got[c].n_ee == 3'd0) got[c].ee_off = 4'(k);
          if (got[c].n_ee != 3'd7) got[c].n_ee = got[c].n_ee + 3'd1;
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      exp = exp_sig(v.kind, rd_lat[c], (c == 0) ? v.d0 : v.d1, (c == 0) ? v.x0 : v.x1);
      n_checks++;
      if (got[c] !== exp) begin
        n_err++;
        $display("FAIL vec%0d dut%0d: got %h expected %h (offsets,counts,wdata,disp)",
                 idx, c, got[c], exp);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial begin
    bit kw, kr;
    out_t o;
    //                rst   wr    rd    kind  d0     d1     x0     x1
    vecs.push_back('{1'b1, 1'b1, 1'b0, K_W,  8'h00, 8'hFE, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b0, K_W,  8'h01, 8'hFF, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b0, K_W,  8'h02, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 1'b1, K_R,  8'h00, 8'h00, 8'h00, 8'hFE});
    vecs.push_back('{1'b0, 1'b0, 1'b1, K_R,  8'h00, 8'h00, 8'h01, 8'hFF});
    vecs.push_back('{1'b0, 1'b0, 1'b1, K_R,  8'h00, 8'h00, 8'h02, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 1'b1, K_EE, 8'h00, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 1'b0, K_W,  8'h00, 8'hFE, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b0, K_W,  8'h01, 8'hFF, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b0, K_W,  8'h02, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b0, K_W,  8'h03, 8'h01, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b0, K_FF, 8'h00, 8'h00, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 1'b0, K_W,  8'h00, 8'hFE, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, K_B,  8'h01, 8'hFF, 8'h00, 8'hFE});
    vecs.push_back('{1'b0, 1'b1, 1'b0, K_W,  8'h00, 8'hFE, 8'h00, 8'h00});

    rst_n    = 1'b0;
    key_wr_n = 1'b1;
    key_rd_n = 1'b1;
    for (int c = 0; c < 2; c++) model_reset(c);
    apply_drv();
    @(negedge clk);
    check_all();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
    check_val("full_hold_data0", bus0.fifo_data, 8'h04);
    check_val("full_hold_data1", bus1.fifo_data, 8'h02);
    for (int i = 12; i < 14; i++) run_vec(vecs[i], i);

    // Reset while the RD_LAT=3 instance sits in WAIT.
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    o = get_out(1);
    check_val("busy_before_reset", {7'd0, o.busy}, 8'h01);
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1);
    run_vec(vecs[14], 14);

    kw = 1'b1;
    kr = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) kw = ~kw;
      if ($urandom_range(0, 5) == 0) kr = ~kr;
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc(kw, kr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
